// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and loads the IF/ID register.
// Optional performance counters (fetch_cnt, stall_cnt) are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  input  logic        irq,
  output logic [30:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        irq_ack,
  output logic [31:0] irq_epc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_REDIR,
    SEL_IRQ,
    SEL_HOLD,
    SEL_FLUSH,
    SEL_SEQ
  } sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } ifid_t;

  localparam ifid_t BUBBLE = '0;

  // Bit 31 is the supervisor flag; only the low 31 bits advance and wrap.
  function automatic logic [31:0] inc(input logic [31:0] x);
    return {x[31], x[30:0] + 31'd4};
  endfunction

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic        irq_take;
  logic [31:0] irq_epc_q, irq_epc_d;
  logic        irq_ack_q;
  sel_e        sel;

  assign irq_take = irq & ~pc_q[31] & ~stall & ~exc_req & ~redirect;

  always_comb begin
    if (exc_req)       sel = SEL_EXC;
    else if (redirect) sel = SEL_REDIR;
    else if (irq_take) sel = SEL_IRQ;
    else if (stall)    sel = SEL_HOLD;
    else if (flush)    sel = SEL_FLUSH;
    else               sel = SEL_SEQ;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    pc_d      = pc_q;
    ifid_d    = ifid_q;
    irq_epc_d = irq_epc_q;
    unique case (sel)
      SEL_EXC: begin
        pc_d   = EXC_VEC;
        ifid_d = BUBBLE;
      end
      SEL_REDIR: begin
        pc_d   = redirect_pc & 32'hFFFF_FFFC;
        ifid_d = BUBBLE;
      end
      SEL_IRQ: begin
        pc_d      = IRQ_VEC;
        ifid_d    = BUBBLE;
        irq_epc_d = inc(pc_q);
      end
      SEL_HOLD: begin
        if (flush) ifid_d = BUBBLE;
      end
      SEL_FLUSH: begin
        pc_d   = inc(pc_q);
        ifid_d = BUBBLE;
      end
      default: begin
        pc_d   = inc(pc_q);
        ifid_d = '{valid: 1'b1, instr: rom_data, pc: pc_q, pc_plus4: inc(pc_q)};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (reset) begin
      pc_q      <= RESET_PC;
      ifid_q    <= BUBBLE;
      irq_ack_q <= 1'b0;
      irq_epc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ifid_q    <= ifid_d;
      irq_ack_q <= irq_take;
      irq_epc_q <= irq_epc_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (sel == SEL_SEQ) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall)          stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  assign pc            = pc_q;
  assign rom_addr      = pc_q[30:0];
  assign ifid_valid    = ifid_q.valid;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign irq_ack       = irq_ack_q;
  assign irq_epc       = irq_epc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; the ROM returns 0x08000002 at address 0 and {1'b1, addr} elsewhere.
// Build with IF_PERF_CNT_EN defined to also exercise the performance counters.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        exc_req = 1'b0;
  logic        irq = 1'b0;
  logic [30:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        irq_ack;
  logic [31:0] irq_epc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rom_data = (rom_addr == 31'd0) ? 32'h0800_0002 : {1'b1, rom_addr};

  if_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .exc_req      (exc_req),
    .irq          (irq),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pc           (pc),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4),
    .irq_ack      (irq_ack),
    .irq_epc      (irq_epc)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [31:0] target);
    redirect = 1'b1; redirect_pc = target;
    step();
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc: got %h want 80000000", pc); end
    checks++; if (rom_addr !== 31'd0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_ifid: valid %b instr %h want 0 0", ifid_valid, ifid_instr); end
    checks++; if (ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc: %h %h want 0 0", ifid_pc, ifid_pc_plus4); end
    checks++; if (irq_ack !== 1'b0 || irq_epc !== 32'h0) begin errors++; $display("FAIL reset_irq: ack %b epc %h want 0 0", irq_ack, irq_epc); end
`ifdef IF_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: %0d %0d want 0 0", fetch_cnt, stall_cnt); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    step();
    checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL seq_pc1: got %h want 80000004", pc); end
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h0800_0002) begin errors++; $display("FAIL seq_instr1: valid %b instr %h want 1 08000002", ifid_valid, ifid_instr); end
    checks++; if (ifid_pc !== 32'h8000_0000 || ifid_pc_plus4 !== 32'h8000_0004) begin errors++; $display("FAIL seq_ifid_pc1: %h %h want 80000000 80000004", ifid_pc, ifid_pc_plus4); end
    step();
    checks++; if (pc !== 32'h8000_0008) begin errors++; $display("FAIL seq_pc2: got %h want 80000008", pc); end
    checks++; if (ifid_instr !== 32'h8000_0004 || ifid_pc !== 32'h8000_0004) begin errors++; $display("FAIL seq_instr2: instr %h pc %h want 80000004 80000004", ifid_instr, ifid_pc); end
`ifdef IF_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd2) begin errors++; $display("FAIL seq_fetch_cnt: got %0d want 2", fetch_cnt); end
`endif
  endtask

  task automatic test_redirect();
    go_to(32'h0000_004E);
    checks++; if (pc !== 32'h0000_004C) begin errors++; $display("FAIL redir_pc: got %h want 0000004c", pc); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc !== 32'h0) begin errors++; $display("FAIL redir_bubble: valid %b instr %h pc %h want 0 0 0", ifid_valid, ifid_instr, ifid_pc); end
    step();
    checks++; if (pc !== 32'h0000_0050) begin errors++; $display("FAIL redir_next_pc: got %h want 00000050", pc); end
    checks++; if (ifid_instr !== 32'h8000_004C || ifid_pc_plus4 !== 32'h0000_0050) begin errors++; $display("FAIL redir_fetch: instr %h p4 %h want 8000004c 00000050", ifid_instr, ifid_pc_plus4); end
  endtask

  task automatic test_irq();
    go_to(32'h0000_0260);
    irq = 1'b1;
    step();
    checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL irq_pc: got %h want 80000004", pc); end
    checks++; if (irq_ack !== 1'b1 || irq_epc !== 32'h0000_0264) begin errors++; $display("FAIL irq_ack: ack %b epc %h want 1 00000264", irq_ack, irq_epc); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL irq_bubble: valid %b instr %h want 0 0", ifid_valid, ifid_instr); end
    step();
    checks++; if (irq_ack !== 1'b0 || irq_epc !== 32'h0000_0264) begin errors++; $display("FAIL irq_one_pulse: ack %b epc %h want 0 00000264", irq_ack, irq_epc); end
    checks++; if (pc !== 32'h8000_0008 || ifid_pc !== 32'h8000_0004) begin errors++; $display("FAIL irq_handler: pc %h ifid_pc %h want 80000008 80000004", pc, ifid_pc); end
    irq = 1'b0;
  endtask

  task automatic test_irq_masked();
    go_to(32'h8000_0010);
    irq = 1'b1;
    step();
    checks++; if (irq_ack !== 1'b0 || pc !== 32'h8000_0014) begin errors++; $display("FAIL irq_masked: ack %b pc %h want 0 80000014", irq_ack, pc); end
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8000_0010) begin errors++; $display("FAIL irq_masked_fetch: valid %b pc %h want 1 80000010", ifid_valid, ifid_pc); end
    go_to(32'h0000_0100);
    checks++; if (pc !== 32'h0000_0100 || irq_ack !== 1'b0) begin errors++; $display("FAIL irq_return: pc %h ack %b want 00000100 0", pc, irq_ack); end
    step();
    checks++; if (irq_ack !== 1'b1 || irq_epc !== 32'h0000_0104 || pc !== 32'h8000_0004) begin errors++; $display("FAIL irq_user_take: ack %b epc %h pc %h want 1 00000104 80000004", irq_ack, irq_epc, pc); end
    irq = 1'b0;
    step();
    checks++; if (irq_ack !== 1'b0 || irq_epc !== 32'h0000_0104) begin errors++; $display("FAIL irq_epc_hold: ack %b epc %h want 0 00000104", irq_ack, irq_epc); end
  endtask

  task automatic test_stall();
    go_to(32'h0000_0200);
    step();
    stall = 1'b1; irq = 1'b1;
    step();
    checks++; if (pc !== 32'h0000_0204 || irq_ack !== 1'b0) begin errors++; $display("FAIL stall_hold_pc: pc %h ack %b want 00000204 0", pc, irq_ack); end
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0000_0200 || ifid_instr !== 32'h8000_0200) begin errors++; $display("FAIL stall_hold_ifid: valid %b pc %h instr %h want 1 00000200 80000200", ifid_valid, ifid_pc, ifid_instr); end
    flush = 1'b1;
    step();
    checks++; if (pc !== 32'h0000_0204 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc !== 32'h0) begin errors++; $display("FAIL stall_flush: pc %h valid %b instr %h ifid_pc %h want 00000204 0 0 0", pc, ifid_valid, ifid_instr, ifid_pc); end
    flush = 1'b0;
    step();
    checks++; if (pc !== 32'h0000_0204 || ifid_valid !== 1'b0) begin errors++; $display("FAIL stall_bubble_hold: pc %h valid %b want 00000204 0", pc, ifid_valid); end
    irq = 1'b0; exc_req = 1'b1;
    step();
    checks++; if (pc !== 32'h8000_0008 || ifid_valid !== 1'b0) begin errors++; $display("FAIL stall_exc: pc %h valid %b want 80000008 0", pc, ifid_valid); end
`ifdef IF_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL stall_cnt: got %0d want 4", stall_cnt); end
`endif
    stall = 1'b0; exc_req = 1'b0;
    step();
    checks++; if (pc !== 32'h8000_000C || ifid_valid !== 1'b1 || ifid_pc !== 32'h8000_0008) begin errors++; $display("FAIL post_stall: pc %h valid %b ifid_pc %h want 8000000c 1 80000008", pc, ifid_valid, ifid_pc); end
    flush = 1'b1;
    step();
    checks++; if (pc !== 32'h8000_0010 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL flush_alone: pc %h valid %b instr %h want 80000010 0 0", pc, ifid_valid, ifid_instr); end
    flush = 1'b0;
  endtask

  task automatic test_priority();
    go_to(32'h0000_0300);
    exc_req = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0400; irq = 1'b1;
    step();
    checks++; if (pc !== 32'h8000_0008 || ifid_valid !== 1'b0) begin errors++; $display("FAIL prio_exc: pc %h valid %b want 80000008 0", pc, ifid_valid); end
    exc_req = 1'b0; redirect = 1'b0; irq = 1'b0;
    step();
    checks++; if (irq_ack !== 1'b0 || pc !== 32'h8000_000C) begin errors++; $display("FAIL prio_no_ack: ack %b pc %h want 0 8000000c", irq_ack, pc); end
  endtask

  task automatic test_wrap();
    go_to(32'h7FFF_FFFC);
    step();
    checks++; if (pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_user_pc: got %h want 00000000", pc); end
    checks++; if (ifid_pc !== 32'h7FFF_FFFC || ifid_pc_plus4 !== 32'h0000_0000 || ifid_instr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_user_ifid: pc %h p4 %h instr %h want 7ffffffc 00000000 fffffffc", ifid_pc, ifid_pc_plus4, ifid_instr); end
    go_to(32'hFFFF_FFFC);
    step();
    checks++; if (pc !== 32'h8000_0000 || ifid_pc_plus4 !== 32'h8000_0000) begin errors++; $display("FAIL wrap_sup: pc %h p4 %h want 80000000 80000000", pc, ifid_pc_plus4); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; exc_req = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0500;
    step();
    checks++; if (pc !== 32'h8000_0000 || ifid_valid !== 1'b0 || irq_epc !== 32'h0) begin errors++; $display("FAIL reset_mid: pc %h valid %b epc %h want 80000000 0 0", pc, ifid_valid, irq_epc); end
    reset = 1'b0; exc_req = 1'b0; redirect = 1'b0;
    step();
    checks++; if (pc !== 32'h8000_0004 || ifid_instr !== 32'h0800_0002) begin errors++; $display("FAIL reset_mid_restart: pc %h instr %h want 80000004 08000002", pc, ifid_instr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_irq();
    test_irq_masked();
    test_stall();
    test_priority();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
